// File: rtl/usb_fs_in_pe.sv
// USB full-speed IN protocol engine: per-endpoint packet buffers with data
// toggles, plus a transfer FSM that answers IN tokens with STALL/NAK/DATAx
// and waits for the host handshake, with a bit-time timeout.

// Per-endpoint buffer, fill pointer, toggle and READY/PUTTING/ARMED/STALL state.
module usb_fs_in_pe_ep #(
  parameter int MAX_IN_PACKET_SIZE = 32,
  parameter int AW = 5,
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reset_ep_i,
  input  logic          put_i,
  input  logic [7:0]    data_i,
  input  logic          done_i,
  input  logic          stall_i,
  input  logic          setup_i,
  input  logic          ack_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          ready_o,
  output logic          armed_o,
  output logic          stall_o,
  output logic          toggle_o,
  output logic [PW-1:0] put_ptr_o,
  output logic [7:0]    rd_data_o
);
  typedef enum logic [1:0] {EP_READY, EP_PUTTING, EP_ARMED, EP_STALL} ep_state_e;

  ep_state_e     state_q, state_d;
  logic [PW-1:0] put_ptr_q, put_ptr_d;
  logic          toggle_q, toggle_d;
  logic          wr_en;
  logic [7:0]    mem_q [MAX_IN_PACKET_SIZE];

  // Next state; reset_ep beats stall, stall beats everything else.
  // put_ptr survives entry to STALL so a payload already in flight completes;
  // the buffer is emptied when STALL is left.
  always_comb begin
    state_d   = state_q;
    put_ptr_d = put_ptr_q;
    toggle_d  = toggle_q;
    wr_en     = 1'b0;
    case (state_q)
      EP_READY, EP_PUTTING: begin
        if (put_i) begin
          state_d = EP_PUTTING;
          if (put_ptr_q < PW'(MAX_IN_PACKET_SIZE)) begin
            wr_en     = 1'b1;
            put_ptr_d = put_ptr_q + PW'(1);
          end
        end
        if (done_i) state_d = EP_ARMED;
      end
      EP_ARMED: begin
        if (ack_i) begin
          state_d   = EP_READY;
          put_ptr_d = '0;
          toggle_d  = ~toggle_q;
        end
      end
      EP_STALL: begin
        if (setup_i) begin
          state_d   = EP_READY;
          put_ptr_d = '0;
        end
      end
      default: state_d = EP_READY;
    endcase
    if (setup_i) toggle_d = 1'b1;
    if (stall_i) begin
      state_d = EP_STALL;
      wr_en   = 1'b0;
    end
    if (reset_ep_i) begin
      state_d   = EP_READY;
      put_ptr_d = '0;
      toggle_d  = 1'b0;
      wr_en     = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EP_READY;
      put_ptr_q <= '0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      put_ptr_q <= put_ptr_d;
      toggle_q  <= toggle_d;
    end
  end

  // Packet storage, no reset needed: only bytes below put_ptr are ever read out.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[put_ptr_q[AW-1:0]] <= data_i;
  end

  assign ready_o   = (state_q == EP_READY);
  assign armed_o   = (state_q == EP_ARMED);
  assign stall_o   = (state_q == EP_STALL);
  assign toggle_o  = toggle_q;
  assign put_ptr_o = put_ptr_q;
  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// Top: token decode, transfer FSM and endpoint array.
module usb_fs_in_pe #(
  parameter int NUM_IN_EPS         = 1,
  parameter int MAX_IN_PACKET_SIZE = 32,
  parameter int ACK_TIMEOUT_BITS   = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IN_EPS-1:0] reset_ep,
  input  logic [6:0]            dev_addr,
  input  logic                  bit_strobe,
  output logic [NUM_IN_EPS-1:0] in_ep_data_free,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
  input  logic [7:0]            in_ep_data,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
  input  logic [NUM_IN_EPS-1:0] in_ep_stall,
  output logic [NUM_IN_EPS-1:0] in_ep_acked,
  input  logic                  rx_pkt_start,
  input  logic                  rx_pkt_end,
  input  logic                  rx_pkt_valid,
  input  logic [3:0]            rx_pid,
  input  logic [6:0]            rx_addr,
  input  logic [3:0]            rx_endp,
  output logic                  tx_pkt_start,
  input  logic                  tx_pkt_end,
  output logic [3:0]            tx_pid,
  output logic                  tx_data_avail,
  input  logic                  tx_data_get,
  output logic [7:0]            tx_data
);
  localparam int AW = $clog2(MAX_IN_PACKET_SIZE);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT_BITS + 1);

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [1:0] {X_IDLE, X_RCVD_IN, X_SEND, X_WAIT_ACK} xfr_state_e;

  xfr_state_e    xfr_q, xfr_d;
  logic [3:0]    current_endp_q, current_endp_d;
  logic [PW-1:0] get_ptr_q, get_ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    tx_pid_q, tx_pid_d;

  logic [NUM_IN_EPS-1:0]         ep_ready, ep_armed, ep_stall, ep_toggle, ep_ack, cur_sel;
  logic [NUM_IN_EPS-1:0][PW-1:0] ep_put_ptr;
  logic [NUM_IN_EPS-1:0][7:0]    ep_rdata;

  logic          tok_match, in_tok, setup_tok, ack_hit, cur_rst;
  logic          cur_armed, cur_stall, cur_toggle;
  logic [PW-1:0] cur_put_ptr;
  logic [7:0]    cur_rdata;
  logic          unused_rx_start;

  // Start-of-packet is not needed: everything keys off the end strobe.
  assign unused_rx_start = rx_pkt_start;

  // Tokens addressed to one of our endpoints; only honoured while idle.
  assign tok_match = rx_pkt_end && rx_pkt_valid && (rx_pid[1:0] == 2'b01) &&
                     (rx_addr == dev_addr) && ({28'd0, rx_endp} < 32'(NUM_IN_EPS));
  assign in_tok    = tok_match && (rx_pid == PID_IN) && (xfr_q == X_IDLE);
  assign setup_tok = tok_match && (rx_pid == PID_SETUP) && (xfr_q == X_IDLE);

  for (genvar i = 0; i < NUM_IN_EPS; i++) begin : g_ep
    usb_fs_in_pe_ep #(
      .MAX_IN_PACKET_SIZE (MAX_IN_PACKET_SIZE),
      .AW                 (AW),
      .PW                 (PW)
    ) u_ep (
      .clk        (clk),
      .reset      (reset),
      .reset_ep_i (reset_ep[i]),
      .put_i      (in_ep_data_put[i]),
      .data_i     (in_ep_data),
      .done_i     (in_ep_data_done[i]),
      .stall_i    (in_ep_stall[i]),
      .setup_i    (setup_tok && (rx_endp == 4'(i))),
      .ack_i      (ep_ack[i]),
      .rd_addr_i  (get_ptr_q[AW-1:0]),
      .ready_o    (ep_ready[i]),
      .armed_o    (ep_armed[i]),
      .stall_o    (ep_stall[i]),
      .toggle_o   (ep_toggle[i]),
      .put_ptr_o  (ep_put_ptr[i]),
      .rd_data_o  (ep_rdata[i])
    );
  end

  // Select the endpoint the current transfer is talking to.
  always_comb begin
    cur_sel     = '0;
    cur_armed   = 1'b0;
    cur_stall   = 1'b0;
    cur_toggle  = 1'b0;
    cur_put_ptr = '0;
    cur_rdata   = '0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (current_endp_q == 4'(i)) begin
        cur_sel[i]  = 1'b1;
        cur_armed   = ep_armed[i];
        cur_stall   = ep_stall[i];
        cur_toggle  = ep_toggle[i];
        cur_put_ptr = ep_put_ptr[i];
        cur_rdata   = ep_rdata[i];
      end
    end
  end

  assign cur_rst = |(reset_ep & cur_sel);

  // Transfer FSM: next state, tx strobe/PID, handshake detection.
  always_comb begin
    xfr_d          = xfr_q;
    current_endp_d = current_endp_q;
    get_ptr_d      = get_ptr_q;
    timer_d        = timer_q;
    tx_pid_d       = tx_pid_q;
    tx_pkt_start   = 1'b0;
    ack_hit        = 1'b0;
    case (xfr_q)
      X_IDLE: begin
        if (in_tok) begin
          current_endp_d = rx_endp;
          xfr_d          = X_RCVD_IN;
        end
      end
      X_RCVD_IN: begin
        tx_pkt_start = 1'b1;
        get_ptr_d    = '0;
        if (cur_stall) begin
          tx_pid_d = PID_STALL;
          xfr_d    = X_IDLE;
        end else if (!cur_armed) begin
          tx_pid_d = PID_NAK;
          xfr_d    = X_IDLE;
        end else begin
          tx_pid_d = cur_toggle ? PID_DATA1 : PID_DATA0;
          xfr_d    = X_SEND;
        end
      end
      X_SEND: begin
        if (tx_data_get && tx_data_avail) get_ptr_d = get_ptr_q + PW'(1);
        if (tx_pkt_end) begin
          timer_d = '0;
          xfr_d   = X_WAIT_ACK;
        end
      end
      X_WAIT_ACK: begin
        if (bit_strobe) timer_d = timer_q + TW'(1);
        if (rx_pkt_end) begin
          ack_hit = rx_pkt_valid && (rx_pid == PID_ACK);
          xfr_d   = X_IDLE;
        end else if (timer_q == TW'(ACK_TIMEOUT_BITS)) begin
          xfr_d = X_IDLE;
        end
      end
      default: xfr_d = X_IDLE;
    endcase
    // Resetting the endpoint we are serving aborts the transfer silently.
    if (cur_rst && (xfr_q != X_IDLE)) begin
      xfr_d        = X_IDLE;
      tx_pkt_start = 1'b0;
      tx_pid_d     = tx_pid_q;
      ack_hit      = 1'b0;
    end
  end

  // Transfer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfr_q          <= X_IDLE;
      current_endp_q <= '0;
      get_ptr_q      <= '0;
      timer_q        <= '0;
      tx_pid_q       <= '0;
    end else begin
      xfr_q          <= xfr_d;
      current_endp_q <= current_endp_d;
      get_ptr_q      <= get_ptr_d;
      timer_q        <= timer_d;
      tx_pid_q       <= tx_pid_d;
    end
  end

  // A handshake only counts for an endpoint still armed (not stalled meanwhile).
  assign ep_ack          = {NUM_IN_EPS{ack_hit}} & cur_sel & ep_armed;
  assign in_ep_acked     = ep_ack;
  assign in_ep_data_free = ep_ready;
  assign tx_pid          = tx_pid_d;
  assign tx_data_avail   = (xfr_q == X_SEND) && (get_ptr_q < cur_put_ptr);
  assign tx_data         = (xfr_q == X_SEND) ? cur_rdata : 8'd0;
endmodule
